stack_sequencer: RTL and testbench

- Parametrised call/return micro-sequencer for the E0C6S46-style core.
- Generalises the hard-wired RET/RETS/RETD handling into one block that runs CALL, CALZ, RET, RETS and RETD against nibble RAM.
- Stack depth in nibbles is configurable.
- Sits between the decoder/microcode and the RAM arbiter; owns SP and the return-path X update while busy.

---
 rtl/stack_seq_pkg.sv | 30 +++
 rtl/pcs_increment.sv | 21 ++
 rtl/stack_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the call/return micro-sequencer.
package stack_seq_pkg;

    // Stack operations accepted on the op port; any other code is ignored.
    typedef enum logic [2:0] {
        OP_CALL = 3'd0,
        OP_CALZ = 3'd1,
        OP_RET  = 3'd2,
        OP_RETS = 3'd3,
        OP_RETD = 3'd4
    } stack_op_t;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_RD,
        POP_CAP,
        IMM_WR,
        DONE
    } state_t;

    // Nibble positions inside a stacked PC frame, lowest address first.
    localparam int NIB_PCSL = 0;
    localparam int NIB_PCSH = 1;
    localparam int NIB_PCP  = 2;

    // RETD stores the immediate as two nibbles at X and X+1.
    localparam int RETD_WRITES = 2;

endpackage

// File: rtl/pcs_increment.sv
// PCS+1 that wraps inside the current page; PCP and bank bit pass through.
module pcs_increment
    import stack_seq_pkg::*;
#(
    parameter int PC_W     = 13,
    parameter int NIBBLE_W = 4
) (
    input  logic [PC_W-1:0] i_pc,
    output logic [PC_W-1:0] o_pc
);

    localparam int PCS_LO = NIB_PCSL * NIBBLE_W;
    localparam int PCS_W  = (NIB_PCSH - NIB_PCSL + 1) * NIBBLE_W;

    // Increment only the in-page step field so a carry never reaches PCP.
    always_comb begin
        o_pc = i_pc;
        o_pc[PCS_LO +: PCS_W] = i_pc[PCS_LO +: PCS_W] + PCS_W'(1);
    end

endmodule

// File: rtl/stack_sequencer.sv
// Call/return micro-sequencer: pushes/pops PC frames in nibble RAM for
// CALL, CALZ, RET, RETS and RETD, and produces the new PC, SP and X.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int PC_NIBBLES = 3,
    parameter int NIBBLE_W   = 4,
    parameter int ADDR_W     = 12,
    parameter int SP_W       = 8,
    parameter int PC_W       = 13
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [PC_W-1:0]     pc_in,
    input  logic [PC_W-2:0]     target_in,
    input  logic [7:0]          imm_in,
    input  logic [SP_W-1:0]     sp_in,
    input  logic [ADDR_W-1:0]   x_in,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [NIBBLE_W-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [NIBBLE_W-1:0] mem_rdata,
    output logic                busy,
    output logic                done,
    output logic [PC_W-1:0]     pc_out,
    output logic [SP_W-1:0]     sp_out,
    output logic [ADDR_W-1:0]   x_out
);

    localparam int PCS_W  = PC_W - 1;
    localparam int K_W    = $clog2(PC_NIBBLES + 1);
    localparam int PAGE_W = NIB_PCP * NIBBLE_W;
    localparam logic [K_W-1:0] K_LAST    = K_W'(PC_NIBBLES - 1);
    localparam logic [K_W-1:0] K_WR_LAST = K_W'(RETD_WRITES - 1);

    state_t              r_state, w_state_nxt;
    logic [K_W-1:0]      r_k, w_k_nxt;
    logic                w_load, w_cap, w_set_call, w_set_ret, w_set_x;
    stack_op_t           r_op;
    logic [PC_W-1:0]     r_pc;
    logic [PCS_W-1:0]    r_tgt;
    logic [7:0]          r_imm;
    logic [SP_W-1:0]     r_sp;
    logic [ADDR_W-1:0]   r_x;
    logic [NIBBLE_W-1:0] r_pop [PC_NIBBLES];
    logic [NIBBLE_W-1:0] w_ret_nib [PC_NIBBLES];
    logic [K_W-1:0]      w_cap_idx, w_push_idx;
    logic [PC_W-1:0]     w_ret_pc, w_pop_pc, w_rets_pc, w_call_pc;
    logic [SP_W-1:0]     w_push_sp, w_pop_sp;
    logic [ADDR_W-1:0]   w_x_hi_addr;
    logic [PC_W-1:0]     r_pc_out;
    logic [SP_W-1:0]     r_sp_out;
    logic [ADDR_W-1:0]   r_x_out;

    // Return address pushed by CALL/CALZ, and the RETS skip over the popped PC.
    pcs_increment #(.PC_W(PC_W), .NIBBLE_W(NIBBLE_W)) u_call_inc (.i_pc(r_pc),     .o_pc(w_ret_pc));
    pcs_increment #(.PC_W(PC_W), .NIBBLE_W(NIBBLE_W)) u_rets_inc (.i_pc(w_pop_pc), .o_pc(w_rets_pc));

    // Reads return data one cycle late, so POP_RD captures the previous nibble
    // and POP_CAP captures the last one at the current counter value.
    assign w_cap_idx   = (r_state == POP_CAP) ? r_k : r_k - K_W'(1);
    assign w_push_idx  = K_LAST - r_k;
    assign w_push_sp   = r_sp - SP_W'(r_k) - SP_W'(1);
    assign w_pop_sp    = r_sp + SP_W'(r_k);
    assign w_x_hi_addr = {r_x[ADDR_W-1:8], r_x[7:0] + 8'd1};
    assign w_call_pc   = (r_op == OP_CALZ)
                       ? {r_pc[PC_W-1], {(PCS_W-PAGE_W){1'b0}}, r_tgt[PAGE_W-1:0]}
                       : {r_pc[PC_W-1], r_tgt};

    // Split the return address into nibbles and assemble the popped PC,
    // bypassing the nibble arriving this cycle straight from RAM.
    always_comb begin
        w_pop_pc = '0;
        w_pop_pc[PC_W-1] = r_pc[PC_W-1];
        for (int i = 0; i < PC_NIBBLES; i++) begin
            w_ret_nib[i] = w_ret_pc[i*NIBBLE_W +: NIBBLE_W];
            if (w_cap && (w_cap_idx == K_W'(i))) begin
                w_pop_pc[i*NIBBLE_W +: NIBBLE_W] = mem_rdata;
            end else begin
                w_pop_pc[i*NIBBLE_W +: NIBBLE_W] = r_pop[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and RAM strobes; mem_we and mem_re are never set together.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_load      = 1'b0;
        w_cap       = 1'b0;
        w_set_call  = 1'b0;
        w_set_ret   = 1'b0;
        w_set_x     = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_CALL, OP_CALZ: begin
                            w_state_nxt = PUSH;
                            w_k_nxt     = '0;
                            w_load      = 1'b1;
                        end
                        OP_RET, OP_RETS, OP_RETD: begin
                            w_state_nxt = POP_RD;
                            w_k_nxt     = '0;
                            w_load      = 1'b1;
                        end
                        default: w_state_nxt = IDLE;
                    endcase
                end
            end
            PUSH: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(w_push_sp);
                mem_wdata = w_ret_nib[w_push_idx];
                if (r_k == K_LAST) begin
                    w_state_nxt = DONE;
                    w_set_call  = 1'b1;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
            POP_RD: begin
                mem_re   = 1'b1;
                mem_addr = ADDR_W'(w_pop_sp);
                w_cap    = (r_k != '0);
                if (r_k == K_LAST) w_state_nxt = POP_CAP;
                else               w_k_nxt     = r_k + K_W'(1);
            end
            POP_CAP: begin
                w_cap     = 1'b1;
                w_set_ret = 1'b1;
                if (r_op == OP_RETD) begin
                    w_state_nxt = IMM_WR;
                    w_k_nxt     = '0;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            IMM_WR: begin
                mem_we    = 1'b1;
                mem_addr  = (r_k == '0) ? r_x : w_x_hi_addr;
                mem_wdata = (r_k == '0) ? NIBBLE_W'(r_imm[3:0]) : NIBBLE_W'(r_imm[7:4]);
                if (r_k == K_WR_LAST) begin
                    w_state_nxt = DONE;
                    w_set_x     = 1'b1;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Nibble counter and result registers; results hold until the next op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k      <= '0;
            r_pc_out <= '0;
            r_sp_out <= '0;
            r_x_out  <= '0;
        end else begin
            r_k <= w_k_nxt;
            if (w_set_call) begin
                r_pc_out <= w_call_pc;
                r_sp_out <= r_sp - SP_W'(PC_NIBBLES);
                r_x_out  <= r_x;
            end
            if (w_set_ret) begin
                r_pc_out <= (r_op == OP_RETS) ? w_rets_pc : w_pop_pc;
                r_sp_out <= r_sp + SP_W'(PC_NIBBLES);
                r_x_out  <= r_x;
            end
            if (w_set_x) begin
                r_x_out <= {r_x[ADDR_W-1:8], r_x[7:0] + 8'd2};
            end
        end
    end

    // Operand snapshot at start and the popped-nibble buffer.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_op  <= stack_op_t'(op);
            r_pc  <= pc_in;
            r_tgt <= target_in;
            r_imm <= imm_in;
            r_sp  <= sp_in;
            r_x   <= x_in;
        end
        if (w_cap) r_pop[w_cap_idx] <= mem_rdata;
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign pc_out = r_pc_out;
    assign sp_out = r_sp_out;
    assign x_out  = r_x_out;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed cases plus random ops against a stack model.
module tb_stack_sequencer;
    import stack_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [12:0] pc_in = '0;
    logic [11:0] target_in = '0;
    logic [7:0]  imm_in = '0;
    logic [7:0]  sp_in = '0;
    logic [11:0] x_in = '0;
    logic [11:0] mem_addr;
    logic [3:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [3:0]  rdata_q;
    logic        busy, done;
    logic [12:0] pc_out;
    logic [7:0]  sp_out;
    logic [11:0] x_out;

    logic        start4 = 1'b0;
    logic [2:0]  op4 = 3'd0;
    logic [16:0] pc4 = '0;
    logic [15:0] tgt4 = '0;
    logic [7:0]  imm4 = '0;
    logic [7:0]  sp4 = '0;
    logic [11:0] x4 = '0;
    logic [11:0] addr4;
    logic [3:0]  wdata4, rdata4;
    logic        we4, re4, busy4, done4;
    logic [16:0] pcout4;
    logic [7:0]  spout4;
    logic [11:0] xout4;

    logic [3:0]  ram [4096];
    logic [3:0]  exp_ram [4096];
    logic [3:0]  ram4 [4096];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [3:0]  poke_data = '0;
    int          wr_cnt = 0, excl_err = 0, wr4 = 0;
    int          total = 0, bad = 0;
    logic [12:0] prev_pc = '0;
    logic [7:0]  prev_sp = '0;
    logic [11:0] prev_x = '0;

    always #5 clk = ~clk;

    stack_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .pc_in(pc_in),
        .target_in(target_in), .imm_in(imm_in), .sp_in(sp_in), .x_in(x_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(rdata_q), .busy(busy), .done(done), .pc_out(pc_out),
        .sp_out(sp_out), .x_out(x_out)
    );

    stack_sequencer #(.PC_NIBBLES(4), .PC_W(17)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op4), .pc_in(pc4),
        .target_in(tgt4), .imm_in(imm4), .sp_in(sp4), .x_in(x4),
        .mem_addr(addr4), .mem_wdata(wdata4), .mem_we(we4), .mem_re(re4),
        .mem_rdata(rdata4), .busy(busy4), .done(done4), .pc_out(pcout4),
        .sp_out(spout4), .x_out(xout4)
    );

    function automatic logic [3:0] init_val(input int i);
        return 4'((i * 7 + 3) ^ (i >> 5));
    endfunction

    // Nibble RAM with one-cycle read latency, plus write/exclusivity counters.
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (poke_en) ram[poke_addr] <= poke_data;
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
            if (mem_re) rdata_q <= ram[mem_addr];
            if (mem_we && mem_re) excl_err <= excl_err + 1;
        end
    end

    // RAM for the four-nibble build: address i holds (i+1) mod 16.
    initial begin
        for (int i = 0; i < 4096; i++) ram4[i] = 4'(i + 1);
        forever begin
            @(posedge clk);
            if (re4) rdata4 <= ram4[addr4];
            if (we4) begin
                ram4[addr4] <= wdata4;
                wr4 <= wr4 + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [3:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
        exp_ram[a] = d;
    endtask

    // Predict the op from stack semantics, run it, and compare everything.
    task automatic run_op(input logic [2:0] o, input logic [12:0] p, input logic [11:0] t,
                          input logic [7:0] im, input logic [7:0] s, input logic [11:0] xx,
                          input int glitch_at, input int rst_at);
        logic [12:0] e_pc, ret;
        logic [7:0]  e_sp, ssp;
        logic [11:0] e_x, val;
        int e_cyc, e_wr, cyc, lim, wr0, ex0, m;
        bit valid, seen, rst_hit;
        valid = (o <= 3'd4);
        e_pc = prev_pc; e_sp = prev_sp; e_x = prev_x; e_cyc = 0; e_wr = 0;
        if (o == OP_CALL || o == OP_CALZ) begin
            ret = {p[12:8], p[7:0] + 8'd1};
            ssp = s;
            for (int i = 2; i >= 0; i--) begin
                ssp = ssp - 8'd1;
                if (rst_at == 0) exp_ram[{4'h0, ssp}] = ret[i*4 +: 4];
            end
            e_sp = ssp; e_x = xx; e_cyc = 4; e_wr = 3;
            e_pc = (o == OP_CALL) ? {p[12], t} : {p[12], 4'h0, t[7:0]};
        end else if (valid) begin
            ssp = s;
            for (int i = 0; i < 3; i++) begin
                val[i*4 +: 4] = exp_ram[{4'h0, ssp}];
                ssp = ssp + 8'd1;
            end
            e_pc = {p[12], val};
            if (o == OP_RETS) e_pc[7:0] = e_pc[7:0] + 8'd1;
            e_sp = ssp; e_x = xx; e_cyc = 5;
            if (o == OP_RETD) begin
                if (rst_at == 0) begin
                    exp_ram[xx] = im[3:0];
                    exp_ram[{xx[11:8], xx[7:0] + 8'd1}] = im[7:4];
                end
                e_x = {xx[11:8], xx[7:0] + 8'd2};
                e_cyc = 7; e_wr = 2;
            end
        end
        wr0 = wr_cnt; ex0 = excl_err;
        @(negedge clk);
        op = o; pc_in = p; target_in = t; imm_in = im; sp_in = s; x_in = xx; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1; seen = 0; rst_hit = 0; lim = valid ? 20 : 8;
        while (cyc <= lim && !seen && !rst_hit) begin
            if (cyc == 1 && valid) chk("busy", busy, 1);
            if (cyc == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_pc", pc_out, 0);
                chk("rst_spx", {sp_out, x_out}, 0);
                chk("rst_ctl", {busy, done, mem_we, mem_re}, 0);
                chk("rst_addr", mem_addr, 0);
                rst_hit = 1;
            end else if (done) begin
                seen = 1;
            end else begin
                if (cyc == glitch_at) begin
                    start = 1'b1; op = OP_CALL;
                end
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end
        end
        if (rst_hit) begin
            repeat (2) begin
                @(negedge clk);
                chk("rst_hold", {busy, done, mem_we, mem_re}, 0);
            end
            reset = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("rst_quiet", {busy, done}, 0);
            end
            chk("rst_nowr", wr_cnt - wr0, 0);
            prev_pc = '0; prev_sp = '0; prev_x = '0;
        end else if (valid) begin
            chk("seen_done", seen, 1);
            chk("done_cyc", cyc, e_cyc);
            chk("pc", pc_out, e_pc);
            chk("sp", sp_out, e_sp);
            chk("x", x_out, e_x);
            chk("writes", wr_cnt - wr0, e_wr);
            @(negedge clk);
            chk("after_done", {busy, done}, 0);
            chk("hold_pc", pc_out, e_pc);
            chk("hold_spx", {sp_out, x_out}, {e_sp, e_x});
            prev_pc = e_pc; prev_sp = e_sp; prev_x = e_x;
        end else begin
            chk("inv_nodone", seen, 0);
            chk("inv_busy", busy, 0);
            chk("inv_pc", pc_out, prev_pc);
            chk("inv_spx", {sp_out, x_out}, {prev_sp, prev_x});
            chk("inv_wr", wr_cnt - wr0, 0);
        end
        chk("excl", excl_err - ex0, 0);
        m = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== exp_ram[i]) m++;
        chk("ram", m, 0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [7:0]  rs;
        logic [11:0] rx;
        int          cyc;
        for (int i = 0; i < 4096; i++) exp_ram[i] = init_val(i);

        repeat (3) @(negedge clk);
        chk("por_pc", pc_out, 0);
        chk("por_spx", {sp_out, x_out}, 0);
        chk("por_ctl", {busy, done, mem_we, mem_re}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ctl", {busy, done, mem_we, mem_re}, 0);

        poke(12'h044, 4'hD); poke(12'h045, 4'h4); poke(12'h046, 4'h7);
        run_op(OP_RET, 13'h0AB0, 12'h000, 8'h00, 8'h44, 12'h123, 0, 0);
        chk("lit_ret_pc", pc_out, 13'h074D);
        chk("lit_ret_sp", sp_out, 8'h47);
        chk("lit_ret_x", x_out, 12'h123);
        run_op(OP_RETS, 13'h0AB0, 12'h000, 8'h00, 8'h44, 12'h123, 0, 0);
        chk("lit_rets_pc", pc_out, 13'h074E);

        poke(12'h044, 4'hF); poke(12'h045, 4'hF);
        run_op(OP_RETS, 13'h0AB0, 12'h000, 8'h00, 8'h44, 12'h123, 0, 0);
        chk("lit_rets_wrap", pc_out, 13'h0700);
        poke(12'h044, 4'hD); poke(12'h045, 4'h4);

        run_op(OP_RETD, 13'h0000, 12'h000, 8'hFC, 8'h44, 12'h4F1, 0, 0);
        chk("lit_retd_lo", ram[12'h4F1], 4'hC);
        chk("lit_retd_hi", ram[12'h4F2], 4'hF);
        chk("lit_retd_x", x_out, 12'h4F3);
        chk("lit_retd_pc", pc_out, 13'h074D);
        run_op(OP_RETD, 13'h0000, 12'h000, 8'hFC, 8'h44, 12'h4FF, 0, 0);
        chk("lit_retd_wlo", ram[12'h4FF], 4'hC);
        chk("lit_retd_whi", ram[12'h400], 4'hF);
        chk("lit_retd_wx", x_out, 12'h401);

        run_op(OP_CALL, 13'h0123, 12'h456, 8'h00, 8'h00, 12'h222, 0, 0);
        chk("lit_call_ff", ram[12'h0FF], 4'h1);
        chk("lit_call_fe", ram[12'h0FE], 4'h2);
        chk("lit_call_fd", ram[12'h0FD], 4'h4);
        chk("lit_call_sp", sp_out, 8'hFD);
        chk("lit_call_pc", pc_out, 13'h0456);
        run_op(OP_CALZ, 13'h1FFF, 12'hABC, 8'h00, 8'h10, 12'h333, 0, 0);
        chk("lit_calz_pc", pc_out, 13'h10BC);
        chk("lit_calz_pcsl", ram[12'h00D], 4'h0);

        run_op(OP_RET, 13'h0AB0, 12'h000, 8'h00, 8'h44, 12'h123, 2, 0);
        chk("lit_glitch_pc", pc_out, 13'h074D);
        run_op(OP_RETD, 13'h0000, 12'h000, 8'h5A, 8'h44, 12'h4F1, 0, 2);
        run_op(3'd5, 13'h0123, 12'h456, 8'h00, 8'h20, 12'h111, 0, 0);
        run_op(OP_RET, 13'h1000, 12'h000, 8'h00, 8'hFE, 12'h111, 0, 0);

        for (int n = 0; n < 40; n++) begin
            ro = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0:       rs = 8'hFF;
                1:       rs = 8'h00;
                2:       rs = 8'hFE;
                default: rs = 8'($urandom);
            endcase
            rx = 12'($urandom);
            if ($urandom_range(0, 2) == 0) rx[7:0] = 8'($urandom_range(254, 255));
            run_op(ro, 13'($urandom), 12'($urandom), 8'($urandom), rs, rx, 0, 0);
        end

        @(negedge clk);
        op4 = OP_RET; pc4 = 17'h10ABC; sp4 = 8'h10; x4 = 12'h321; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; cyc = 1;
        while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("n4_cyc", cyc, 6);
        chk("n4_pc", pcout4, 17'h14321);
        chk("n4_sp", spout4, 8'h14);
        chk("n4_x", xout4, 12'h321);
        chk("n4_wr", wr4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
